// File: rtl/rt_gray_cnt.sv
// Up/down counter publishing its state as binary and Gray code, both taken straight from flops
// so the Gray word can cross clock domains glitch-free.
module rt_gray_cnt #(
    parameter int PARAM_BIT_NUM  = 4,
    parameter int PARAM_SATURATE = 0
) (
    input  logic                     rt_i_clk,
    input  logic                     rt_i_rst_n,
    input  logic                     rt_i_clr,
    input  logic                     rt_i_load,
    input  logic [PARAM_BIT_NUM-1:0] rt_i_load_bin,
    input  logic                     rt_i_en,
    input  logic                     rt_i_dir,
    output logic [PARAM_BIT_NUM-1:0] rt_o_bin,
    output logic [PARAM_BIT_NUM-1:0] rt_o_gray,
    output logic                     rt_o_wrap,
    output logic                     rt_o_sat,
    output logic                     rt_o_jump
);

    localparam logic [PARAM_BIT_NUM-1:0] ZERO = '0;
    localparam logic [PARAM_BIT_NUM-1:0] ONE  = PARAM_BIT_NUM'(1);
    localparam logic [PARAM_BIT_NUM-1:0] MAX  = '1;
    localparam logic                     SAT  = (PARAM_SATURATE != 0);

    logic [PARAM_BIT_NUM-1:0] bin_q, bin_d;
    logic [PARAM_BIT_NUM-1:0] gray_q, gray_d;
    logic [PARAM_BIT_NUM-1:0] gray_diff;
    logic                     wrap_q, wrap_d;
    logic                     sat_q, sat_d;
    logic                     jump_q, jump_d;
    logic                     at_end;

    always_comb begin
        bin_d     = bin_q;
        wrap_d    = 1'b0;
        at_end    = (rt_i_dir && (bin_q == MAX)) || (!rt_i_dir && (bin_q == ZERO));

        if (rt_i_clr) begin
            bin_d = ZERO;
        end else if (rt_i_load) begin
            bin_d = rt_i_load_bin;
        end else if (rt_i_en && !(SAT && at_end)) begin
            bin_d  = rt_i_dir ? (bin_q + ONE) : (bin_q - ONE);
            wrap_d = at_end;
        end

        // Gray is encoded from the next binary value so both flops load on the same edge.
        gray_d    = bin_d ^ (bin_d >> 1);
        gray_diff = gray_q ^ gray_d;
        // Clearing the lowest set bit leaves a non-zero word only if two or more bits differ.
        jump_d    = (gray_diff & (gray_diff - ONE)) != ZERO;
        sat_d     = SAT && ((rt_i_dir && (bin_d == MAX)) || (!rt_i_dir && (bin_d == ZERO)));
    end

    always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
        if (!rt_i_rst_n) begin
            bin_q  <= ZERO;
            gray_q <= ZERO;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
            jump_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
            jump_q <= jump_d;
        end
    end

    assign rt_o_bin  = bin_q;
    assign rt_o_gray = gray_q;
    assign rt_o_wrap = wrap_q;
    assign rt_o_sat  = sat_q;
    assign rt_o_jump = jump_q;

endmodule
